alu_arbiter: RTL and testbench

//   Shares the single registered ALU (1-cycle latency, res/cond written on clock edge) between two

---
 rtl/alu_arbiter.sv | 158 +++++++++++++++
 tb/tb_alu_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between an execute-stage port (0) and a branch-compare port (1).
// Define ALU_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module alu_arbiter #(
  parameter int XLEN = 32,
  parameter int OPW  = 4
) (
  input  logic            clock,
  input  logic            reset,

  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OPW-1:0]  req0_op,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,

  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OPW-1:0]  req1_op,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,

  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [XLEN-1:0] rsp0_res,
  output logic            rsp0_cond,

  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp1_res,
  output logic            rsp1_cond,

  output logic [OPW-1:0]  alu_op,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_res,
  input  logic            alu_cond,

  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic grant;
  logic pick1;
  logic accept;
  logic rsp_done;

`ifdef ALU_ARB_RR_EN
  logic last_grant;
`endif

  // Arbitration: pick1 is high when port 1 would win a request this cycle.
  always_comb begin
    pick1 = 1'b0;
`ifdef ALU_ARB_RR_EN
    if (req0_valid && req1_valid) begin
      pick1 = ~last_grant;
    end else begin
      pick1 = req1_valid;
    end
`else
    pick1 = req1_valid && !req0_valid;
`endif
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!reset && state == IDLE) begin
      req0_ready = req0_valid && !pick1;
      req1_ready = pick1;
    end
    accept   = req0_ready || req1_ready;
    rsp_done = grant ? rsp1_ready : rsp0_ready;
    busy     = (state != IDLE);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = EXEC;
      EXEC: state_next = CAPT;
      CAPT: state_next = RESP;
      RESP: if (rsp_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      grant <= 1'b0;
`ifdef ALU_ARB_RR_EN
      last_grant <= 1'b1;
`endif
    end else begin
      state <= state_next;
      if (accept) begin
        grant <= pick1;
`ifdef ALU_ARB_RR_EN
        last_grant <= pick1;
`endif
      end
    end
  end

  // ALU operands change only on an accept, so the ALU sees them stable through EXEC.
  always_ff @(posedge clock) begin
    if (reset) begin
      alu_op <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
    end else if (accept) begin
      alu_op <= pick1 ? req1_op : req0_op;
      alu_a  <= pick1 ? req1_a  : req0_a;
      alu_b  <= pick1 ? req1_b  : req0_b;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rsp0_valid <= 1'b0;
      rsp0_res   <= '0;
      rsp0_cond  <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_res   <= '0;
      rsp1_cond  <= 1'b0;
    end else begin
      if (state == CAPT) begin
        if (grant) begin
          rsp1_valid <= 1'b1;
          rsp1_res   <= alu_res;
          rsp1_cond  <= alu_cond;
        end else begin
          rsp0_valid <= 1'b1;
          rsp0_res   <= alu_res;
          rsp0_cond  <= alu_cond;
        end
      end
      if (state == RESP && rsp_done) begin
        if (grant) begin
          rsp1_valid <= 1'b0;
        end else begin
          rsp0_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: table of single ops plus hand-written
// timing, back-pressure, reset and arbitration sequences, all scored from a queue.
module tb_alu_arbiter;

  localparam int XLEN = 32;
  localparam int OPW  = 4;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;
  localparam logic [3:0] OP_EQ  = 4'd8;
  localparam logic [3:0] OP_NE  = 4'd9;
  localparam logic [3:0] OP_LT  = 4'd10;
  localparam logic [3:0] OP_GE  = 4'd11;
  localparam logic [3:0] OP_LTU = 4'd12;
  localparam logic [3:0] OP_GEU = 4'd13;

  logic            clock;
  logic            reset;
  logic            req0_valid, req0_ready;
  logic [OPW-1:0]  req0_op;
  logic [XLEN-1:0] req0_a, req0_b;
  logic            req1_valid, req1_ready;
  logic [OPW-1:0]  req1_op;
  logic [XLEN-1:0] req1_a, req1_b;
  logic            rsp0_valid, rsp0_ready, rsp0_cond;
  logic [XLEN-1:0] rsp0_res;
  logic            rsp1_valid, rsp1_ready, rsp1_cond;
  logic [XLEN-1:0] rsp1_res;
  logic [OPW-1:0]  alu_op;
  logic [XLEN-1:0] alu_a, alu_b;
  logic [XLEN-1:0] alu_res = '0;
  logic            alu_cond = 1'b0;
  logic            busy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        port;
    logic [31:0] res;
    logic        cond;
    logic        chk_res;
    logic        chk_cond;
    string       name;
  } exp_t;

  typedef struct {
    logic        port;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        cond;
    logic        chk_res;
    logic        chk_cond;
    string       name;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[11];

  alu_arbiter #(.XLEN(XLEN), .OPW(OPW)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_res(rsp0_res), .rsp0_cond(rsp0_cond),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_res(rsp1_res), .rsp1_cond(rsp1_cond),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_res(alu_res), .alu_cond(alu_cond),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Registered ALU: arithmetic ops update res, compares update cond, unknown ops zero res.
  always @(posedge clock) begin
    case (alu_op)
      OP_ADD: alu_res <= alu_a + alu_b;
      OP_SUB: alu_res <= alu_a - alu_b;
      OP_AND: alu_res <= alu_a & alu_b;
      OP_OR:  alu_res <= alu_a | alu_b;
      OP_XOR: alu_res <= alu_a ^ alu_b;
      OP_SLL: alu_res <= alu_a << alu_b[4:0];
      OP_SRL: alu_res <= alu_a >> alu_b[4:0];
      OP_SRA: alu_res <= $unsigned($signed(alu_a) >>> alu_b[4:0]);
      OP_EQ:  alu_cond <= (alu_a == alu_b);
      OP_NE:  alu_cond <= (alu_a != alu_b);
      OP_LT:  alu_cond <= ($signed(alu_a) < $signed(alu_b));
      OP_GE:  alu_cond <= ($signed(alu_a) >= $signed(alu_b));
      OP_LTU: alu_cond <= (alu_a < alu_b);
      OP_GEU: alu_cond <= (alu_a >= alu_b);
      default: alu_res <= '0;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    end
  endtask

  function automatic exp_t mkExp(input logic port, input logic [31:0] res, input logic cond,
                                 input logic chk_res, input logic chk_cond, input string name);
    exp_t e;
    e.port = port; e.res = res; e.cond = cond;
    e.chk_res = chk_res; e.chk_cond = chk_cond; e.name = name;
    return e;
  endfunction

  function automatic vec_t mkVec(input logic port, input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] res, input logic cond,
                                 input logic chk_res, input logic chk_cond, input string name);
    vec_t v;
    v.port = port; v.op = op; v.a = a; v.b = b; v.res = res; v.cond = cond;
    v.chk_res = chk_res; v.chk_cond = chk_cond; v.name = name;
    return v;
  endfunction

  task automatic scoreResponse(input logic port, input logic [31:0] res, input logic cond,
                               input logic other_valid);
    exp_t e;
    if (exp_q.size() == 0) begin
      checkOutput("rsp_unexpected", 32'(port) + 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    checkOutput({e.name, "_port"}, 32'(port), 32'(e.port));
    if (e.chk_res) checkOutput({e.name, "_res"}, res, e.res);
    if (e.chk_cond) checkOutput({e.name, "_cond"}, 32'(cond), 32'(e.cond));
    checkOutput({e.name, "_other_valid"}, 32'(other_valid), 32'd0);
  endtask

  // Response monitor samples well after the falling edge, once drivers have settled.
  always @(negedge clock) begin
    #2;
    if (!reset) begin
      if (rsp0_valid && rsp0_ready) scoreResponse(1'b0, rsp0_res, rsp0_cond, rsp1_valid);
      if (rsp1_valid && rsp1_ready) scoreResponse(1'b1, rsp1_res, rsp1_cond, rsp0_valid);
    end
  end

  task automatic driveReq(input logic port, input logic valid, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b);
    if (port) begin
      req1_valid = valid; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = valid; req0_op = op; req0_a = a; req0_b = b;
    end
  endtask

  task automatic waitReady(input logic port, output logic ok);
    int c = 0;
    #1;
    while (!(port ? req1_ready : req0_ready) && c < 20) begin
      @(negedge clock); #1;
      c++;
    end
    ok = port ? req1_ready : req0_ready;
    if (!ok) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitIdle();
    int c = 0;
    do begin
      @(negedge clock); #3;
      c++;
    end while ((busy || exp_q.size() != 0) && c < 40);
    if (busy || exp_q.size() != 0) begin
      checkOutput("idle_timeout", 32'd0, 32'd1);
      exp_q.delete();
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    logic ok;
    @(negedge clock);
    driveReq(v.port, 1'b1, v.op, v.a, v.b);
    exp_q.push_back(mkExp(v.port, v.res, v.cond, v.chk_res, v.chk_cond, v.name));
    waitReady(v.port, ok);
    if (!ok) void'(exp_q.pop_back());
    @(negedge clock);
    driveReq(v.port, 1'b0, v.op, v.a, v.b);
  endtask

  task automatic resetDut();
    @(negedge clock);
    reset = 1'b1;
    driveReq(1'b0, 1'b0, OP_ADD, 32'd0, 32'd0);
    driveReq(1'b1, 1'b0, OP_ADD, 32'd0, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic ok;
    logic p;
    logic exp_g;

    vecs[0]  = mkVec(1'b0, OP_SUB, 32'd3,          32'd5,          32'hFFFF_FFFE, 1'b0, 1'b1, 1'b1, "v0_sub");
    vecs[1]  = mkVec(1'b1, OP_LT,  32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFE, 1'b1, 1'b1, 1'b1, "v1_lt");
    vecs[2]  = mkVec(1'b1, OP_LTU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFE, 1'b0, 1'b1, 1'b1, "v2_ltu");
    vecs[3]  = mkVec(1'b0, OP_AND, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000, 1'b0, 1'b1, 1'b1, "v3_and");
    vecs[4]  = mkVec(1'b1, OP_EQ,  32'd9,          32'd9,          32'hF000_F000, 1'b1, 1'b1, 1'b1, "v4_eq");
    vecs[5]  = mkVec(1'b0, OP_XOR, 32'hFFFF_0000,  32'h0F0F_0F0F,  32'hF0F0_0F0F, 1'b1, 1'b1, 1'b1, "v5_xor");
    vecs[6]  = mkVec(1'b1, OP_GE,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'hF0F0_0F0F, 1'b1, 1'b1, 1'b1, "v6_ge");
    vecs[7]  = mkVec(1'b0, 4'hF,   32'd9,          32'd9,          32'd0,         1'b1, 1'b1, 1'b1, "v7_badop0");
    vecs[8]  = mkVec(1'b1, 4'hE,   32'd1,          32'd2,          32'd0,         1'b1, 1'b1, 1'b1, "v8_badop1");
    vecs[9]  = mkVec(1'b0, OP_ADD, 32'hFFFF_FFFF,  32'd2,          32'd1,         1'b1, 1'b1, 1'b1, "v9_addwrap");
    vecs[10] = mkVec(1'b1, OP_GEU, 32'd1,          32'hFFFF_FFFF,  32'd1,         1'b0, 1'b1, 1'b1, "v10_geu");

    reset = 1'b1;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    driveReq(1'b0, 1'b0, OP_ADD, 32'd0, 32'd0);
    driveReq(1'b1, 1'b0, OP_ADD, 32'd0, 32'd0);

    // Reset state, with both requests valid to show ready is held off during reset.
    repeat (2) @(negedge clock);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    checkOutput("rst_req0_ready", 32'(req0_ready), 32'd0);
    checkOutput("rst_req1_ready", 32'(req1_ready), 32'd0);
    checkOutput("rst_busy",       32'(busy),       32'd0);
    checkOutput("rst_alu_op",     32'(alu_op),     32'd0);
    checkOutput("rst_alu_a",      alu_a,           32'd0);
    checkOutput("rst_alu_b",      alu_b,           32'd0);
    checkOutput("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    checkOutput("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    checkOutput("rst_rsp0_res",   rsp0_res,        32'd0);
    checkOutput("rst_rsp1_res",   rsp1_res,        32'd0);
    checkOutput("rst_rsp0_cond",  32'(rsp0_cond),  32'd0);
    checkOutput("rst_rsp1_cond",  32'(rsp1_cond),  32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;

    // Single ADD with cycle-accurate ready, busy and response timing.
    @(negedge clock);
    driveReq(1'b0, 1'b1, OP_ADD, 32'd5, 32'd7);
    exp_q.push_back(mkExp(1'b0, 32'd12, 1'b0, 1'b1, 1'b1, "t1_add"));
    #1;
    checkOutput("t1_req0_ready", 32'(req0_ready), 32'd1);
    checkOutput("t1_req1_ready", 32'(req1_ready), 32'd0);
    @(negedge clock); #1;
    checkOutput("t1_ready_pulse", 32'(req0_ready), 32'd0);
    checkOutput("t1_busy_exec",   32'(busy),       32'd1);
    driveReq(1'b0, 1'b0, OP_ADD, 32'd5, 32'd7);
    @(negedge clock); #1;
    checkOutput("t1_valid_capt",  32'(rsp0_valid), 32'd0);
    checkOutput("t1_busy_capt",   32'(busy),       32'd1);
    @(negedge clock); #1;
    checkOutput("t1_valid_resp",  32'(rsp0_valid), 32'd1);
    checkOutput("t1_res_resp",    rsp0_res,        32'd12);
    checkOutput("t1_busy_resp",   32'(busy),       32'd1);
    @(negedge clock); #1;
    checkOutput("t1_valid_done",  32'(rsp0_valid), 32'd0);
    checkOutput("t1_busy_done",   32'(busy),       32'd0);
    waitIdle();

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
      waitIdle();
    end

    // Back-pressure on port 0 while port 1 waits.
    rsp0_ready = 1'b0;
    @(negedge clock);
    driveReq(1'b0, 1'b1, OP_ADD, 32'd20, 32'd22);
    exp_q.push_back(mkExp(1'b0, 32'd42, 1'b0, 1'b1, 1'b0, "t4_add"));
    waitReady(1'b0, ok);
    @(negedge clock);
    driveReq(1'b0, 1'b0, OP_ADD, 32'd20, 32'd22);
    driveReq(1'b1, 1'b1, OP_SUB, 32'd10, 32'd4);
    exp_q.push_back(mkExp(1'b1, 32'd6, 1'b0, 1'b1, 1'b0, "t4_sub"));
    begin
      int c = 0;
      #1;
      while (!rsp0_valid && c < 10) begin
        @(negedge clock); #1;
        c++;
      end
    end
    for (int k = 0; k < 5; k++) begin
      checkOutput("t4_hold_valid",  32'(rsp0_valid), 32'd1);
      checkOutput("t4_hold_res",    rsp0_res,        32'd42);
      checkOutput("t4_req1_blocked", 32'(req1_ready), 32'd0);
      @(negedge clock); #1;
    end
    rsp0_ready = 1'b1;
    @(negedge clock); #1;
    checkOutput("t4_req1_ready_idle", 32'(req1_ready), 32'd1);
    checkOutput("t4_busy_idle",       32'(busy),       32'd0);
    @(negedge clock);
    driveReq(1'b1, 1'b0, OP_SUB, 32'd10, 32'd4);
    waitIdle();

    // Reset during EXEC discards the op; the still-valid request is re-arbitrated.
    @(negedge clock);
    driveReq(1'b0, 1'b1, OP_ADD, 32'd1, 32'd1);
    waitReady(1'b0, ok);
    @(negedge clock);
    reset = 1'b1;
    exp_q.delete();
    driveReq(1'b0, 1'b1, OP_SUB, 32'd3, 32'd5);
    @(negedge clock); #1;
    checkOutput("t5_busy",       32'(busy),       32'd0);
    checkOutput("t5_alu_op",     32'(alu_op),     32'd0);
    checkOutput("t5_alu_a",      alu_a,           32'd0);
    checkOutput("t5_alu_b",      alu_b,           32'd0);
    checkOutput("t5_rsp0_valid", 32'(rsp0_valid), 32'd0);
    checkOutput("t5_rsp1_valid", 32'(rsp1_valid), 32'd0);
    checkOutput("t5_rsp0_res",   rsp0_res,        32'd0);
    checkOutput("t5_rsp1_res",   rsp1_res,        32'd0);
    checkOutput("t5_req0_ready", 32'(req0_ready), 32'd0);
    reset = 1'b0;
    exp_q.push_back(mkExp(1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, "t5_sub"));
    waitReady(1'b0, ok);
    @(negedge clock);
    driveReq(1'b0, 1'b0, OP_SUB, 32'd3, 32'd5);
    waitIdle();

    // Both ports request continuously from a fresh reset.
    resetDut();
    @(negedge clock);
    driveReq(1'b0, 1'b1, OP_ADD, 32'd10, 32'd1);
    driveReq(1'b1, 1'b1, OP_ADD, 32'd200, 32'd1);
    for (int g = 0; g < 4; g++) begin
      int c = 0;
      #1;
      while (!(req0_ready || req1_ready) && c < 20) begin
        @(negedge clock); #1;
        c++;
      end
      if (!(req0_ready || req1_ready)) begin
        checkOutput("t3_grant_timeout", 32'd0, 32'd1);
        break;
      end
      p = req1_ready;
`ifdef ALU_ARB_RR_EN
      exp_g = (g % 2 == 1);
`else
      exp_g = 1'b0;
`endif
      checkOutput($sformatf("t3_grant%0d", g), 32'(p), 32'(exp_g));
      checkOutput("t3_single_ready", 32'(req0_ready && req1_ready), 32'd0);
      exp_q.push_back(mkExp(p, (p ? req1_a : req0_a) + 32'd1, 1'b0, 1'b1, 1'b0,
                            $sformatf("t3_op%0d", g)));
      @(negedge clock);
      if (p) req1_a = req1_a + 32'd1;
      else   req0_a = req0_a + 32'd1;
    end
    driveReq(1'b0, 1'b0, OP_ADD, 32'd0, 32'd0);
    driveReq(1'b1, 1'b0, OP_ADD, 32'd0, 32'd0);
    waitIdle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
